rom_text_fetcher: RTL and testbench

// - Downstream consumer of input_ROM: walks the ROM from a start address, reading one byte of message text at a time.
// - Buffers characters in a small FIFO and presents them on a valid/ready stream to the Morse encoder.
// - Stops at the 0x00 terminator or at the last ROM address, then reports done once the FIFO has drained.

---
 rtl/morse_pkg.sv | 26 ++
 rtl/rom_text_fetcher_if.sv | 32 +++
 rtl/text_fifo.sv | 63 ++++++
 rtl/rom_text_fetcher.sv | 145 ++++++++++++++
 tb/tb_rom_text_fetcher.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : morse_pkg
//  Purpose  : Shared widths, character constants and fetcher state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package morse_pkg;

  localparam int MORSE_ADR_W  = 17;
  localparam int MORSE_DATA_W = 8;

  localparam logic [7:0] EOT_CHAR   = 8'h00;
  localparam logic [7:0] LOWER_A    = 8'h61;
  localparam logic [7:0] LOWER_Z    = 8'h7A;
  localparam logic [7:0] CASE_DELTA = 8'h20;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DRAIN = 3'd4
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/rom_text_fetcher_if.sv
`default_nettype none
// ============================================================================
//  Module   : rom_text_fetcher_if
//  Purpose  : Control, ROM read bus and character stream of the text fetcher.
//  Revision : 1.0 - initial release
// ============================================================================
interface rom_text_fetcher_if #(
  parameter int ADR_W  = 17,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADR_W-1:0]  start_adr;
  logic              busy;
  logic              done;
  logic              rom_cs;
  logic [ADR_W-1:0]  rom_adr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] char;
  logic              char_valid;
  logic              char_ready;

  modport master (
    input  start, start_adr, rom_data, char_ready,
    output busy, done, rom_cs, rom_adr, char, char_valid
  );

  modport slave (
    output start, start_adr, rom_data, char_ready,
    input  busy, done, rom_cs, rom_adr, char, char_valid
  );
endinterface
`default_nettype wire

// File: rtl/text_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : text_fifo
//  Purpose  : Small synchronous FIFO (power-of-two depth) for fetched text.
//  Revision : 1.0 - initial release
// ============================================================================
module text_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] push_data,
  input  wire logic             pop,
  output logic      [WIDTH-1:0] head,
  output logic                  empty,
  output logic                  full,
  output logic      [CNT_W-1:0] free_cnt
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head     = r_mem[r_rd_ptr];
  assign empty    = (r_count == '0);
  assign full     = (r_count == CNT_W'(DEPTH));
  assign free_cnt = CNT_W'(DEPTH) - r_count;

endmodule
`default_nettype wire

// File: rtl/rom_text_fetcher.sv
`default_nettype none
// ============================================================================
//  Module   : rom_text_fetcher
//  Purpose  : Walks the ROM from a start address, buffering text bytes into a
//             valid/ready character stream. Optional macro CASE_FOLD_EN folds
//             'a'..'z' to upper case before buffering.
//  Revision : 1.0 - initial release
// ============================================================================
module rom_text_fetcher
  import morse_pkg::*;
#(
  parameter int               ADR_W      = MORSE_ADR_W,
  parameter int               DATA_W     = MORSE_DATA_W,
  parameter int               FIFO_DEPTH = 4,
  parameter int               ROM_LAT    = 1,
  parameter logic [ADR_W-1:0] END_ADR    = {ADR_W{1'b1}}
) (
  input wire logic           clk,
  input wire logic           rst,
  rom_text_fetcher_if.master bus
);

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_ISSUE = ISSUE;
  localparam logic [2:0] ST_WAIT  = WAIT;
  localparam logic [2:0] ST_CHECK = CHECK;
  localparam logic [2:0] ST_DRAIN = DRAIN;

  localparam int LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]        r_state;
  logic [ADR_W-1:0]  r_adr;
  logic [ADR_W-1:0]  r_last_adr;
  logic [LAT_W-1:0]  r_lat;
  logic [DATA_W-1:0] r_data;
  logic              r_busy;
  logic              r_done;

  logic              w_can_issue;
  logic              w_issue;
  logic              w_lat_last;
  logic              w_is_eot;
  logic              w_push;
  logic [DATA_W-1:0] w_push_data;
  logic [DATA_W-1:0] w_head;
  logic              w_empty;
  logic              w_full;
  logic [CNT_W-1:0]  w_free_cnt;

  assign w_can_issue = !w_full && (w_free_cnt != '0);
  assign w_issue     = (r_state == ST_ISSUE) && w_can_issue;
  assign w_lat_last  = (r_lat == LAT_W'(ROM_LAT - 1));
  assign w_is_eot    = (r_data == DATA_W'(EOT_CHAR));
  assign w_push      = (r_state == ST_CHECK) && !w_is_eot;

  // Terminator detection above always looks at the raw byte.
  always_comb begin
    w_push_data = r_data;
`ifdef CASE_FOLD_EN
    if ((r_data >= DATA_W'(LOWER_A)) && (r_data <= DATA_W'(LOWER_Z))) begin
      w_push_data = r_data - DATA_W'(CASE_DELTA);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_adr      <= '0;
      r_last_adr <= '0;
      r_lat      <= '0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_adr   <= bus.start_adr;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_can_issue) begin
            r_last_adr <= r_adr;
            r_lat      <= '0;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_lat_last) begin
            r_data  <= bus.rom_data;
            r_state <= ST_CHECK;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        ST_CHECK: begin
          if (w_is_eot || (r_adr == END_ADR)) begin
            r_state <= ST_DRAIN;
          end else begin
            r_adr   <= r_adr + 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_DRAIN: begin
          if (w_empty) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  text_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (bus.char_ready),
    .head      (w_head),
    .empty     (w_empty),
    .full      (w_full),
    .free_cnt  (w_free_cnt)
  );

  // rom_adr shows the live address only while a read is issued, otherwise the last one.
  assign bus.rom_cs     = w_issue;
  assign bus.rom_adr    = w_issue ? r_adr : r_last_adr;
  assign bus.char       = w_head;
  assign bus.char_valid = !w_empty;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rom_text_fetcher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rom_text_fetcher
//  Purpose  : Directed self-checking bench for rom_text_fetcher (ROM_LAT=1).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rom_text_fetcher;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  rom_text_fetcher_if #(.ADR_W(17), .DATA_W(8)) ifa ();
  rom_text_fetcher_if #(.ADR_W(17), .DATA_W(8)) ifb ();

  rom_text_fetcher #(.ROM_LAT(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  rom_text_fetcher #(.ROM_LAT(1), .END_ADR(17'd5)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  function automatic logic [7:0] rom_byte(input logic [16:0] a);
    case (a)
      17'd0:   return 8'h53;
      17'd1:   return 8'h4F;
      17'd2:   return 8'h53;
      17'd4:   return 8'h45;
      17'd5:   return 8'h54;
      17'd8:   return 8'h50;
      17'd9:   return 8'h41;
      17'd10:  return 8'h52;
      17'd11:  return 8'h49;
      17'd12:  return 8'h53;
      17'd32:  return 8'h61;
      17'd33:  return 8'h62;
      17'd3, 17'd6, 17'd13, 17'd34: return 8'h00;
      default: return 8'h3F;
    endcase
  endfunction

  logic [7:0]  stream_a[$];
  logic [7:0]  stream_b[$];
  logic [16:0] adrs_a[$];
  logic [16:0] adrs_b[$];

  // One-cycle-latency ROM models and stream/address monitors.
  always @(posedge clk) begin
    if (ifa.rom_cs) begin
      ifa.rom_data <= rom_byte(ifa.rom_adr);
      adrs_a.push_back(ifa.rom_adr);
    end
    if (ifb.rom_cs) begin
      ifb.rom_data <= rom_byte(ifb.rom_adr);
      adrs_b.push_back(ifb.rom_adr);
    end
    if (ifa.char_valid && ifa.char_ready) stream_a.push_back(ifa.char);
    if (ifb.char_valid && ifb.char_ready) stream_b.push_back(ifb.char);
  end

  task automatic clear_logs();
    stream_a.delete();
    stream_b.delete();
    adrs_a.delete();
    adrs_b.delete();
  endtask

  task automatic pulse_start_a(input logic [16:0] a);
    ifa.start_adr = a;
    ifa.start     = 1'b1;
    @(negedge clk);
    ifa.start     = 1'b0;
  endtask

  task automatic wait_done_a();
    for (int i = 0; i < 300 && !ifa.done; i++) @(negedge clk);
    n_checks++;
    if (ifa.done !== 1'b1) $display("FAIL done_timeout_a: done=%b required 1", ifa.done);
    else n_pass++;
  endtask

  task automatic check_seq_a(input string name, input logic [7:0] exp_c[$], input logic [16:0] exp_a[$]);
    n_checks++;
    if (stream_a.size() !== exp_c.size())
      $display("FAIL %s_stream_len: got %0d required %0d", name, stream_a.size(), exp_c.size());
    else n_pass++;
    for (int i = 0; i < exp_c.size() && i < stream_a.size(); i++) begin
      n_checks++;
      if (stream_a[i] !== exp_c[i])
        $display("FAIL %s_char[%0d]: got %h required %h", name, i, stream_a[i], exp_c[i]);
      else n_pass++;
    end
    n_checks++;
    if (adrs_a != exp_a) $display("FAIL %s_adrs: got %p required %p", name, adrs_a, exp_a);
    else n_pass++;
    n_checks++;
    if (ifa.busy !== 1'b0) $display("FAIL %s_busy_end: got %b required 0", name, ifa.busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({ifa.rom_cs, ifa.char_valid, ifa.busy, ifa.done} !== 4'b0000)
      $display("FAIL reset_flags: got %b required 0000", {ifa.rom_cs, ifa.char_valid, ifa.busy, ifa.done});
    else n_pass++;
    n_checks++;
    if (ifa.rom_adr !== 17'd0) $display("FAIL reset_rom_adr: got %h required 0", ifa.rom_adr);
    else n_pass++;
  endtask

  task automatic test_sos();
    clear_logs();
    ifa.char_ready = 1'b1;
    pulse_start_a(17'd0);
    n_checks++;
    if (ifa.busy !== 1'b1) $display("FAIL sos_busy: got %b required 1", ifa.busy);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ifa.char_valid !== 1'b0) $display("FAIL sos_early_valid: got %b required 0", ifa.char_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (ifa.char_valid !== 1'b1 || ifa.char !== 8'h53)
      $display("FAIL sos_first_char: valid=%b char=%h required valid=1 char=53", ifa.char_valid, ifa.char);
    else n_pass++;
    wait_done_a();
    check_seq_a("sos", '{8'h53, 8'h4F, 8'h53}, '{17'd0, 17'd1, 17'd2, 17'd3});
  endtask

  task automatic test_backpressure();
    clear_logs();
    ifa.char_ready = 1'b0;
    pulse_start_a(17'd8);
    repeat (30) @(negedge clk);
    n_checks++;
    if (adrs_a.size() !== 4) $display("FAIL bp_reads_while_full: got %0d required 4", adrs_a.size());
    else n_pass++;
    n_checks++;
    if (ifa.char_valid !== 1'b1 || ifa.char !== 8'h50 || ifa.rom_cs !== 1'b0)
      $display("FAIL bp_held_head: valid=%b char=%h cs=%b required 1 50 0", ifa.char_valid, ifa.char, ifa.rom_cs);
    else n_pass++;
    ifa.char_ready = 1'b1;
    wait_done_a();
    check_seq_a("bp", '{8'h50, 8'h41, 8'h52, 8'h49, 8'h53},
                '{17'd8, 17'd9, 17'd10, 17'd11, 17'd12, 17'd13});
  endtask

  task automatic test_case_fold();
    clear_logs();
    ifa.char_ready = 1'b1;
    pulse_start_a(17'd32);
    wait_done_a();
`ifdef CASE_FOLD_EN
    check_seq_a("fold", '{8'h41, 8'h42}, '{17'd32, 17'd33, 17'd34});
`else
    check_seq_a("fold", '{8'h61, 8'h62}, '{17'd32, 17'd33, 17'd34});
`endif
  endtask

  task automatic test_end_adr();
    clear_logs();
    ifb.char_ready = 1'b1;
    ifb.start_adr  = 17'd4;
    ifb.start      = 1'b1;
    @(negedge clk);
    ifb.start      = 1'b0;
    for (int i = 0; i < 300 && !ifb.done; i++) @(negedge clk);
    n_checks++;
    if (ifb.done !== 1'b1) $display("FAIL end_done: got %b required 1", ifb.done);
    else n_pass++;
    n_checks++;
    if (stream_b != '{8'h45, 8'h54}) $display("FAIL end_stream: got %p required E,T", stream_b);
    else n_pass++;
    n_checks++;
    if (adrs_b != '{17'd4, 17'd5}) $display("FAIL end_adrs: got %p required 4,5", adrs_b);
    else n_pass++;
  endtask

  task automatic test_busy_start();
    clear_logs();
    ifa.char_ready = 1'b1;
    pulse_start_a(17'd0);
    repeat (3) @(negedge clk);
    pulse_start_a(17'd8);
    wait_done_a();
    check_seq_a("busy_start", '{8'h53, 8'h4F, 8'h53}, '{17'd0, 17'd1, 17'd2, 17'd3});
  endtask

  task automatic test_rst_mid();
    clear_logs();
    ifa.char_ready = 1'b0;
    pulse_start_a(17'd8);
    repeat (4) @(negedge clk);
    n_checks++;
    if (ifa.char_valid !== 1'b1 || ifa.busy !== 1'b1 || ifa.rom_adr !== 17'd9)
      $display("FAIL rst_pre: valid=%b busy=%b adr=%h required 1 1 9", ifa.char_valid, ifa.busy, ifa.rom_adr);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({ifa.rom_cs, ifa.char_valid, ifa.busy, ifa.done} !== 4'b0000 || ifa.rom_adr !== 17'd0)
      $display("FAIL rst_mid: flags=%b adr=%h required 0000 0",
               {ifa.rom_cs, ifa.char_valid, ifa.busy, ifa.done}, ifa.rom_adr);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    ifa.char_ready = 1'b1;
    pulse_start_a(17'd0);
    wait_done_a();
    check_seq_a("rst_restart", '{8'h53, 8'h4F, 8'h53}, '{17'd0, 17'd1, 17'd2, 17'd3});
  endtask

  initial begin
    ifa.start = 1'b0; ifa.start_adr = '0; ifa.char_ready = 1'b0; ifa.rom_data = '0;
    ifb.start = 1'b0; ifb.start_adr = '0; ifb.char_ready = 1'b0; ifb.rom_data = '0;
    repeat (2) @(negedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_sos();
    test_backpressure();
    test_case_fold();
    test_end_adr();
    test_busy_start();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
